// File: rtl/cms_pkg.sv
// Shared constants and helpers for the trace streamer.
// Build option: define CMS_TIMESTAMP_EN to append a 32-bit cycle timestamp to each packet.
package cms_pkg;

  localparam logic [1:0] FM_ALL      = 2'd0;
  localparam logic [1:0] FM_CTRL     = 2'd1;
  localparam logic [1:0] FM_INDIRECT = 2'd2;
  localparam logic [1:0] FM_NONE     = 2'd3;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int unsigned TS_WIDTH = 32;

  // Packet width: instr + pc + counters (+ timestamp when compiled in).
  function automatic int unsigned cms_pkt_width(int unsigned xlen, int unsigned num_events,
                                                int unsigned cnt_width);
    int unsigned w;
    w = xlen + 32 + num_events * cnt_width;
`ifdef CMS_TIMESTAMP_EN
    w = w + TS_WIDTH;
`endif
    return w;
  endfunction

  // True when the instruction is selected by the given filter mode.
  function automatic logic cms_mode_pass(logic [1:0] mode, logic [31:0] instr);
    logic [6:0] op;
    logic       pass;
    op = instr[6:0];
    case (mode)
      FM_ALL:      pass = 1'b1;
      FM_CTRL:     pass = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
      FM_INDIRECT: pass = (op == OP_JALR);
      default:     pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/cms_trace_streamer_if.sv
// AXI-Stream channel carrying trace packets.
interface cms_trace_streamer_if #(
  parameter int unsigned DATA_WIDTH = 128
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cms_sync_fifo.sv
// First-word-fall-through FIFO with synchronous active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cms_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  // Head is forced to zero when empty so the stream data is clean after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/cms_trace_streamer.sv
// Trace streamer: filters committed instructions, accumulates event counts between
// records, buffers packets and drains them over AXI-Stream with programmable tlast.
// Build option: CMS_TIMESTAMP_EN appends a free-running 32-bit cycle count (MSB end).
module cms_trace_streamer
  import cms_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned EVT_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [1:0]                      filter_mode,
  input  logic [31:0]                     instr,
  input  logic [XLEN-1:0]                 pc,
  input  logic                            pc_valid,
  input  logic [NUM_EVENTS*EVT_WIDTH-1:0] evt,
  input  logic [31:0]                     tlast_interval,
  cms_trace_streamer_if.master            m_axis,
  output logic [31:0]                     overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  localparam int unsigned AXI_DATA_WIDTH = cms_pkt_width(XLEN, NUM_EVENTS, CNT_WIDTH);
  localparam int unsigned SUM_WIDTH = ((CNT_WIDTH > EVT_WIDTH) ? CNT_WIDTH : EVT_WIDTH) + 1;

  logic                            rec;
  logic                            fifo_full, fifo_empty, pop;
  logic [AXI_DATA_WIDTH-1:0]       pkt, fifo_rdata;
  logic [CNT_WIDTH-1:0]            acc_q   [NUM_EVENTS];
  logic [SUM_WIDTH-1:0]            sum     [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]            cnt_sat [NUM_EVENTS];
  logic [NUM_EVENTS*CNT_WIDTH-1:0] cnt_vec;
  logic [31:0]                     overflow_q, beat_q;
  logic                            tlast_hit;

  assign rec = enable & pc_valid & cms_mode_pass(filter_mode, instr);

  // Saturating sum of each accumulator with this cycle's events, packed for the packet.
  always_comb begin
    cnt_vec = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      sum[i]     = SUM_WIDTH'(acc_q[i]) + SUM_WIDTH'(evt[i*EVT_WIDTH +: EVT_WIDTH]);
      cnt_sat[i] = (sum[i] > SUM_WIDTH'({CNT_WIDTH{1'b1}})) ? '1 : sum[i][CNT_WIDTH-1:0];
      cnt_vec[i*CNT_WIDTH +: CNT_WIDTH] = cnt_sat[i];
    end
  end

`ifdef CMS_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Free-running cycle counter sampled into each packet.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign pkt = {ts_q, cnt_vec, pc, instr};
`else
  assign pkt = {cnt_vec, pc, instr};
`endif

  // Accumulators clear on every record, even one dropped for overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVENTS; i++) acc_q[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_EVENTS; i++) acc_q[i] <= rec ? '0 : cnt_sat[i];
    end
  end

  // Saturating count of records lost to a full FIFO (full sampled before any pop).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= '0;
    end else if (rec && fifo_full && (overflow_q != '1)) begin
      overflow_q <= overflow_q + 32'd1;
    end
  end

  cms_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (rec & ~fifo_full),
    .wdata_i (pkt),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign pop = ~fifo_empty & m_axis.tready;
  // >= so a shrunken interval closes the current packet on the next beat.
  assign tlast_hit = (tlast_interval <= 32'd1) || (beat_q >= tlast_interval - 32'd1);

  assign m_axis.tvalid  = ~fifo_empty;
  assign m_axis.tdata   = fifo_rdata;
  assign m_axis.tlast   = ~fifo_empty & tlast_hit;
  assign overflow_count = overflow_q;

  // Beat position within the current AXIS packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= tlast_hit ? 32'd0 : beat_q + 32'd1;
    end else if (!enable && fifo_empty) begin
      beat_q <= '0;
    end
  end

endmodule

// File: tb/tb_cms_trace_streamer.sv
// Self-checking bench for cms_trace_streamer with a queue-based reference model.
module tb_cms_trace_streamer;
  import cms_pkg::*;

  localparam int unsigned XL    = 64;
  localparam int unsigned NE    = 2;
  localparam int unsigned EW    = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = cms_pkt_width(XL, NE, CW);
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int unsigned C0    = 32 + XL;
  localparam int unsigned C1    = 32 + XL + CW;

  logic           clk = 1'b0;
  logic           rst_n, enable, pc_valid;
  logic [1:0]     filter_mode;
  logic [31:0]    instr, tlast_interval, overflow_count;
  logic [XL-1:0]  pc;
  logic [NE*EW-1:0] evt;
  logic [LW-1:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cms_trace_streamer_if #(.DATA_WIDTH(PW)) axis ();

  cms_trace_streamer #(
    .XLEN       (XL),
    .NUM_EVENTS (NE),
    .EVT_WIDTH  (EW),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .filter_mode    (filter_mode),
    .instr          (instr),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .evt            (evt),
    .tlast_interval (tlast_interval),
    .m_axis         (axis),
    .overflow_count (overflow_count),
    .fifo_level     (fifo_level)
  );

  // ---------------- reference model ----------------
  logic [PW-1:0] mq[$];
  int unsigned   macc[NE];
  int unsigned   movf;
  int unsigned   mbeat;
  logic [31:0]   mts;

  function automatic bit m_pass(logic [1:0] m, logic [31:0] i);
    if (m == 2'd0) return 1'b1;
    if (m == 2'd1) return (i[6:0] == 7'h6F) || (i[6:0] == 7'h67) || (i[6:0] == 7'h63);
    if (m == 2'd2) return i[6:0] == 7'h67;
    return 1'b0;
  endfunction

  function automatic bit m_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [PW-1:0] m_head();
    if (mq.size() == 0) return '0;
    return mq[0];
  endfunction

  function automatic bit m_tlast();
    if (mq.size() == 0) return 1'b0;
    return (tlast_interval <= 1) || (mbeat >= tlast_interval - 1);
  endfunction

  task automatic model_step();
    bit            pop, full, tl, rec;
    int unsigned   s;
    logic [PW-1:0] pkt;
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < NE; i++) macc[i] = 0;
      movf = 0; mbeat = 0; mts = 0;
      return;
    end
    pop  = m_valid() && axis.tready;
    full = mq.size() == DEPTH;
    tl   = m_tlast();
    rec  = enable && pc_valid && m_pass(filter_mode, instr);
    pkt  = '0;
    pkt[31:0]   = instr;
    pkt[32 +: XL] = pc;
`ifdef CMS_TIMESTAMP_EN
    pkt[32 + XL + NE*CW +: 32] = mts;
`endif
    for (int i = 0; i < NE; i++) begin
      s = macc[i] + evt[i*EW +: EW];
      if (s > 255) s = 255;
      pkt[32 + XL + i*CW +: CW] = s[CW-1:0];
      if (enable) macc[i] = rec ? 0 : s;
    end
    if (pop) mbeat = tl ? 0 : mbeat + 1;
    else if (!enable && mq.size() == 0) mbeat = 0;
    if (pop) void'(mq.pop_front());
    if (rec && !full) mq.push_back(pkt);
    if (rec && full && movf != 32'hFFFF_FFFF) movf++;
    mts = mts + 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] i, input logic [XL-1:0] p,
                       input logic [NE*EW-1:0] e);
    pc_valid = v; instr = i; pc = p; evt = e;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; filter_mode = 2'd0; tlast_interval = 32'd0;
    axis.tready = 1'b0;
    drive(1'b0, 32'h0, '0, '0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", axis.tvalid); end
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", axis.tlast); end
    checks++; if (axis.tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", axis.tdata); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (overflow_count !== 32'd0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", overflow_count); end
  endtask

  task automatic test_all_mode();
    logic [PW-1:0] got[$];
    bit            tl[$];
    logic [PW-1:0] b;
    enable = 1'b1; filter_mode = 2'd0; tlast_interval = 32'd4; axis.tready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(1'b1, 32'h13 | (c << 20), XL'(64'h1000 + 4*c), '0);
      else       drive(1'b0, 32'h13, '0, '0);
      if (c == 0) begin
        checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL all_first_empty: got %b want 0", axis.tvalid); end
      end
      if (c == 1) begin
        checks++; if (axis.tvalid !== 1'b1) begin errors++; $display("FAIL all_latency: got %b want 1", axis.tvalid); end
      end
      checks++; if (axis.tvalid !== m_valid() || axis.tdata !== m_head() || axis.tlast !== m_tlast()) begin
        errors++; $display("FAIL all_cycle%0d: got v%b l%b %h want v%b l%b %h", c, axis.tvalid,
                           axis.tlast, axis.tdata, m_valid(), m_tlast(), m_head());
      end
      if (axis.tvalid && axis.tready) begin got.push_back(axis.tdata); tl.push_back(axis.tlast); end
      tick();
    end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL all_beats: got %0d want 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      b = got[k];
      checks++; if (b[32 +: XL] !== XL'(64'h1000 + 4*k) || tl[k] !== (k == 3 || k == 7)) begin
        errors++; $display("FAIL all_beat%0d: got pc %h last %b want pc %h last %b", k, b[32 +: XL],
                           tl[k], 64'h1000 + 4*k, (k == 3 || k == 7));
      end
    end
  endtask

  task automatic test_indirect();
    logic [31:0]   seq [4] = '{32'h0000_0013, 32'h0000_006F, 32'h0000_8067, 32'h0000_0063};
    logic [PW-1:0] got[$];
    bit            tl[$];
    logic [PW-1:0] b;
    filter_mode = 2'd2; tlast_interval = 32'd1; axis.tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, seq[c], XL'(64'h2000 + 4*c), '0);
      else       drive(1'b0, 32'h13, '0, '0);
      checks++; if (axis.tvalid !== m_valid() || axis.tdata !== m_head()) begin
        errors++; $display("FAIL ind_cycle%0d: got v%b %h want v%b %h", c, axis.tvalid, axis.tdata,
                           m_valid(), m_head());
      end
      if (axis.tvalid && axis.tready) begin got.push_back(axis.tdata); tl.push_back(axis.tlast); end
      tick();
    end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL ind_beats: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      b = got[0];
      checks++; if (b[31:0] !== 32'h0000_8067 || tl[0] !== 1'b1) begin
        errors++; $display("FAIL ind_instr: got %h last %b want 00008067 last 1", b[31:0], tl[0]);
      end
    end
  endtask

  task automatic test_event_counts();
    logic [PW-1:0] got[$];
    logic [PW-1:0] b;
    filter_mode = 2'd2; tlast_interval = 32'd1; axis.tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 5)       drive(c == 4, (c == 4) ? 32'h8067 : 32'h13, XL'(64'h3000), {8'd0, 8'd3});
      else if (c == 5) drive(1'b1, 32'h8067, XL'(64'h3004), {8'd2, 8'd0});
      else             drive(1'b0, 32'h13, '0, '0);
      checks++; if (axis.tvalid !== m_valid() || axis.tdata !== m_head()) begin
        errors++; $display("FAIL evt_cycle%0d: got v%b %h want v%b %h", c, axis.tvalid, axis.tdata,
                           m_valid(), m_head());
      end
      if (axis.tvalid && axis.tready) got.push_back(axis.tdata);
      tick();
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL evt_beats: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      b = got[0];
      checks++; if (b[C0 +: CW] !== 8'd15 || b[C1 +: CW] !== 8'd0) begin
        errors++; $display("FAIL evt_first: got cnt0 %0d cnt1 %0d want 15 0", b[C0 +: CW], b[C1 +: CW]);
      end
      b = got[1];
      checks++; if (b[C0 +: CW] !== 8'd0 || b[C1 +: CW] !== 8'd2) begin
        errors++; $display("FAIL evt_second: got cnt0 %0d cnt1 %0d want 0 2", b[C0 +: CW], b[C1 +: CW]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [PW-1:0] got[$];
    logic [PW-1:0] b;
    filter_mode = 2'd0; tlast_interval = 32'd1; axis.tready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 3)       drive(1'b0, 32'h13, '0, {8'd0, 8'hFF});
      else if (c == 3) drive(1'b1, 32'h13, XL'(64'h4000), '0);
      else             drive(1'b0, 32'h13, '0, '0);
      if (axis.tvalid && axis.tready) got.push_back(axis.tdata);
      tick();
    end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL sat_beats: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      b = got[0];
      checks++; if (b[C0 +: CW] !== 8'hFF || b[C1 +: CW] !== 8'd0) begin
        errors++; $display("FAIL sat_cnt: got cnt0 %h cnt1 %h want ff 00", b[C0 +: CW], b[C1 +: CW]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] got[$];
    logic [PW-1:0] b;
    filter_mode = 2'd0; tlast_interval = 32'd4; axis.tready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 32'h13, XL'(64'h5000 + 4*c), '0);
      tick();
    end
    drive(1'b0, 32'h13, '0, '0);
    checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    checks++; if (overflow_count !== 32'd3) begin errors++; $display("FAIL ovf_count: got %0d want 3", overflow_count); end
    axis.tready = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (axis.tvalid && axis.tready) got.push_back(axis.tdata);
      tick();
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL ovf_drain: got %0d want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      b = got[k];
      checks++; if (b[32 +: XL] !== XL'(64'h5000 + 4*k)) begin
        errors++; $display("FAIL ovf_order%0d: got pc %h want %h", k, b[32 +: XL], 64'h5000 + 4*k);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit tl[$];
    filter_mode = 2'd0; tlast_interval = 32'd3; axis.tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(c < 2, 32'h13, XL'(64'h6000 + 4*c), '0);
      tick();
    end
    axis.tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h13, XL'(64'h6100 + 4*c), '0);
      tick();
    end
    drive(1'b0, 32'h13, '0, '0);
    checks++; if (axis.tvalid !== 1'b1 || fifo_level !== LW'(3)) begin
      errors++; $display("FAIL rmid_before: got v%b level %0d want v1 level 3", axis.tvalid, fifo_level);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (axis.tvalid !== 1'b0 || fifo_level !== '0 || overflow_count !== 32'd0 || axis.tdata !== '0) begin
      errors++; $display("FAIL rmid_after: got v%b level %0d ovf %0d data %h want v0 0 0 0", axis.tvalid,
                         fifo_level, overflow_count, axis.tdata);
    end
    axis.tready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive(c < 3, 32'h13, XL'(64'h6200 + 4*c), '0);
      if (axis.tvalid && axis.tready) tl.push_back(axis.tlast);
      tick();
    end
    checks++; if (tl.size() != 3) begin errors++; $display("FAIL rmid_beats: got %0d want 3", tl.size()); end
    else begin
      checks++; if (tl[0] !== 1'b0 || tl[1] !== 1'b0 || tl[2] !== 1'b1) begin
        errors++; $display("FAIL rmid_tlast: got %b%b%b want 001", tl[0], tl[1], tl[2]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [5] = '{7'h13, 7'h6F, 7'h67, 7'h63, 7'h33};
    logic [NE*EW-1:0] e;
    for (int c = 0; c < 600; c++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) filter_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) tlast_interval = $urandom_range(0, 5);
      axis.tready = $urandom_range(0, 1);
      for (int i = 0; i < NE; i++) e[i*EW +: EW] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 6, {25'($urandom), ops[$urandom_range(0, 4)]},
            {32'($urandom), 32'($urandom)}, e);
      checks++; if (axis.tvalid !== m_valid() || axis.tdata !== m_head() || axis.tlast !== m_tlast()) begin
        errors++; $display("FAIL rnd_stream%0d: got v%b l%b %h want v%b l%b %h", c, axis.tvalid,
                           axis.tlast, axis.tdata, m_valid(), m_tlast(), m_head());
      end
      checks++; if (fifo_level !== LW'(mq.size()) || overflow_count !== movf) begin
        errors++; $display("FAIL rnd_status%0d: got level %0d ovf %0d want %0d %0d", c, fifo_level,
                           overflow_count, mq.size(), movf);
      end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_all_mode();
    test_indirect();
    test_event_counts();
    test_saturation();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
